lcd1602_responder: RTL and testbench

LCD1602_RESPONDER -- requirements
Module: lcd1602_responder

---
 rtl/lcd1602_responder_if.sv | 10 +
 rtl/lcd1602_responder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_lcd1602_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd1602_responder_if.sv
// HD44780-style parallel bus from an LCD initiator to the lcd1602_responder model.
interface lcd1602_responder_if;
  logic       rs;
  logic       rw;
  logic       enable;
  logic [7:0] data;

  modport master (output rs, rw, enable, data);
  modport slave  (input  rs, rw, enable, data);
endinterface

// File: rtl/lcd1602_responder.sv
// Behavioural HD44780/LCD1602 responder: decodes bus transactions into mode flags and a DDRAM mirror.
// Optional busy-time model enabled by defining LCD_BUSY_MODEL_EN (default build: busy only while executing/clearing).
//
// state   | meaning
// S_IDLE  | accepting transactions; executes a capture or the pending entry
// S_EXEC  | one-cycle post-execute state; branches to clear on command 0x01
// S_CLEAR | writes 0x20 to mirror entries 0..31, one per cycle
module lcd1602_responder #(
  parameter int NUM_DATA_PERLINE  = 16,
  parameter int BUSY_CYCLES       = 2000,
  parameter int CLEAR_BUSY_CYCLES = 82000
) (
  input  logic                clk,
  input  logic                reset,
  lcd1602_responder_if.slave  bus,
  input  logic [4:0]          rd_addr,
  output logic [7:0]          rd_data,
  output logic [6:0]          cursor_addr,
  output logic                display_on,
  output logic                cursor_on,
  output logic                blink_on,
  output logic                entry_inc,
  output logic                two_line,
  output logic                eight_bit,
  output logic                cmd_strobe,
  output logic                data_strobe,
  output logic                err_overrun,
  output logic                err_read,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;

  state_t      state_q, state_d;
  logic        en_s1_q, en_s1_d, en_s2_q, en_s2_d, en_s3_q, en_s3_d;
  logic [6:0]  cursor_q, cursor_d;
  logic        display_on_q, display_on_d, cursor_on_q, cursor_on_d, blink_on_q, blink_on_d;
  logic        entry_inc_q, entry_inc_d, two_line_q, two_line_d, eight_bit_q, eight_bit_d;
  logic        cmd_strobe_q, cmd_strobe_d, data_strobe_q, data_strobe_d;
  logic        err_overrun_q, err_overrun_d, err_read_q, err_read_d;
  logic        exec_clr_q, exec_clr_d;
  logic [4:0]  clr_cnt_q, clr_cnt_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [7:0]  mem_q [2*NUM_DATA_PERLINE];

  logic        cap, cap_wr;
  logic        exec_v, exec_rs, ovr;
  logic [7:0]  exec_data;
  logic        mem_we;
  logic [4:0]  mem_wa;
  logic [7:0]  mem_wd;

`ifdef LCD_BUSY_MODEL_EN
  localparam int CNT_MAX = (BUSY_CYCLES > CLEAR_BUSY_CYCLES) ? BUSY_CYCLES : CLEAR_BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
`else
  logic       pend_v_q, pend_v_d, pend_rs_q, pend_rs_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       unused_params;
  assign unused_params = (BUSY_CYCLES != 0) ^ (CLEAR_BUSY_CYCLES != 0);
`endif

  function automatic logic [6:0] step_cursor(input logic [6:0] a, input logic inc, input logic two);
    logic [6:0] r;
    if (two) begin
      if (inc) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      else     r = (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
    end else begin
      if (inc) r = (a == 7'h4F) ? 7'h00 : a + 7'd1;
      else     r = (a == 7'h00) ? 7'h4F : a - 7'd1;
    end
    return r;
  endfunction

  // Falling edge of the synchronized enable marks a completed bus transaction.
  assign cap    = en_s3_q & ~en_s2_q;
  assign cap_wr = cap & ~bus.rw;

  always_comb begin
    exec_v    = 1'b0;
    exec_rs   = 1'b0;
    exec_data = 8'h00;
    ovr       = 1'b0;
`ifdef LCD_BUSY_MODEL_EN
    if (cap_wr) begin
      if (state_q == S_IDLE && busy_cnt_q == '0) begin
        exec_v    = 1'b1;
        exec_rs   = bus.rs;
        exec_data = bus.data;
      end else begin
        ovr = 1'b1;
      end
    end
`else
    pend_v_d    = pend_v_q;
    pend_rs_d   = pend_rs_q;
    pend_data_d = pend_data_q;
    if (state_q == S_IDLE && pend_v_q) begin
      exec_v    = 1'b1;
      exec_rs   = pend_rs_q;
      exec_data = pend_data_q;
      pend_v_d  = cap_wr;
      if (cap_wr) begin
        pend_rs_d   = bus.rs;
        pend_data_d = bus.data;
      end
    end else if (cap_wr) begin
      if (state_q == S_IDLE) begin
        exec_v    = 1'b1;
        exec_rs   = bus.rs;
        exec_data = bus.data;
      end else if (!pend_v_q) begin
        pend_v_d    = 1'b1;
        pend_rs_d   = bus.rs;
        pend_data_d = bus.data;
      end else begin
        ovr = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (exec_v) state_d = S_EXEC;
      S_EXEC:  state_d = exec_clr_q ? S_CLEAR : S_IDLE;
      S_CLEAR: if (clr_cnt_q == 5'd31) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef LCD_BUSY_MODEL_EN
    busy = (state_q != S_IDLE) || (busy_cnt_q != '0);
`else
    busy = (state_q != S_IDLE);
`endif
  end

  always_comb begin
    en_s1_d       = bus.enable;
    en_s2_d       = en_s1_q;
    en_s3_d       = en_s2_q;
    cursor_d      = cursor_q;
    display_on_d  = display_on_q;
    cursor_on_d   = cursor_on_q;
    blink_on_d    = blink_on_q;
    entry_inc_d   = entry_inc_q;
    two_line_d    = two_line_q;
    eight_bit_d   = eight_bit_q;
    cmd_strobe_d  = 1'b0;
    data_strobe_d = 1'b0;
    err_overrun_d = ovr;
    err_read_d    = cap & bus.rw;
    exec_clr_d    = 1'b0;
    clr_cnt_d     = clr_cnt_q;
    rd_data_d     = mem_q[rd_addr];
    mem_we        = 1'b0;
    mem_wa        = clr_cnt_q;
    mem_wd        = 8'h20;
`ifdef LCD_BUSY_MODEL_EN
    busy_cnt_d = (busy_cnt_q != '0) ? busy_cnt_q - 1'b1 : busy_cnt_q;
`endif

    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      clr_cnt_d = clr_cnt_q + 5'd1;
      if (clr_cnt_q == 5'd31) begin
        cursor_d    = 7'h00;
        entry_inc_d = 1'b1;
      end
    end

    if (exec_v) begin
`ifdef LCD_BUSY_MODEL_EN
      busy_cnt_d = CNT_W'(BUSY_CYCLES);
      if (!exec_rs && exec_data[7:2] == 6'b0 && exec_data[1:0] != 2'b00)
        busy_cnt_d = CNT_W'(CLEAR_BUSY_CYCLES);
`endif
      if (exec_rs) begin
        data_strobe_d = 1'b1;
        // Only columns inside the visible window of either line land in the mirror.
        mem_we   = (cursor_q[5:0] < 6'(NUM_DATA_PERLINE));
        mem_wa   = cursor_q[6] ? 5'(NUM_DATA_PERLINE) + cursor_q[4:0] : cursor_q[4:0];
        mem_wd   = exec_data;
        cursor_d = step_cursor(cursor_q, entry_inc_q, two_line_q);
      end else begin
        cmd_strobe_d = 1'b1;
        casez (exec_data)
          8'b1???????: cursor_d = exec_data[6:0];
          8'b01??????: ;
          8'b001?????: begin
            eight_bit_d = exec_data[4];
            two_line_d  = exec_data[3];
          end
          8'b0001????: if (!exec_data[3]) cursor_d = step_cursor(cursor_q, exec_data[2], two_line_q);
          8'b00001???: begin
            display_on_d = exec_data[2];
            cursor_on_d  = exec_data[1];
            blink_on_d   = exec_data[0];
          end
          8'b000001??: entry_inc_d = exec_data[1];
          8'b0000001?: cursor_d = 7'h00;
          8'b00000001: exec_clr_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_s1_q       <= 1'b0;
      en_s2_q       <= 1'b0;
      en_s3_q       <= 1'b0;
      cursor_q      <= 7'h00;
      display_on_q  <= 1'b0;
      cursor_on_q   <= 1'b0;
      blink_on_q    <= 1'b0;
      entry_inc_q   <= 1'b1;
      two_line_q    <= 1'b0;
      eight_bit_q   <= 1'b1;
      cmd_strobe_q  <= 1'b0;
      data_strobe_q <= 1'b0;
      err_overrun_q <= 1'b0;
      err_read_q    <= 1'b0;
      exec_clr_q    <= 1'b0;
      clr_cnt_q     <= 5'd0;
      rd_data_q     <= 8'h00;
`ifdef LCD_BUSY_MODEL_EN
      busy_cnt_q    <= '0;
`else
      pend_v_q      <= 1'b0;
      pend_rs_q     <= 1'b0;
      pend_data_q   <= 8'h00;
`endif
    end else begin
      en_s1_q       <= en_s1_d;
      en_s2_q       <= en_s2_d;
      en_s3_q       <= en_s3_d;
      cursor_q      <= cursor_d;
      display_on_q  <= display_on_d;
      cursor_on_q   <= cursor_on_d;
      blink_on_q    <= blink_on_d;
      entry_inc_q   <= entry_inc_d;
      two_line_q    <= two_line_d;
      eight_bit_q   <= eight_bit_d;
      cmd_strobe_q  <= cmd_strobe_d;
      data_strobe_q <= data_strobe_d;
      err_overrun_q <= err_overrun_d;
      err_read_q    <= err_read_d;
      exec_clr_q    <= exec_clr_d;
      clr_cnt_q     <= clr_cnt_d;
      rd_data_q     <= rd_data_d;
`ifdef LCD_BUSY_MODEL_EN
      busy_cnt_q    <= busy_cnt_d;
`else
      pend_v_q      <= pend_v_d;
      pend_rs_q     <= pend_rs_d;
      pend_data_q   <= pend_data_d;
`endif
    end
  end

  assign rd_data     = rd_data_q;
  assign cursor_addr = cursor_q;
  assign display_on  = display_on_q;
  assign cursor_on   = cursor_on_q;
  assign blink_on    = blink_on_q;
  assign entry_inc   = entry_inc_q;
  assign two_line    = two_line_q;
  assign eight_bit   = eight_bit_q;
  assign cmd_strobe  = cmd_strobe_q;
  assign data_strobe = data_strobe_q;
  assign err_overrun = err_overrun_q;
  assign err_read    = err_read_q;

endmodule

// File: tb/tb_lcd1602_responder.sv
// Directed bench for lcd1602_responder: event scoreboard on strobes, mirror and flag checks.
module tb_lcd1602_responder;
  localparam logic [3:0] K_CMD = 4'b1000;
  localparam logic [3:0] K_DAT = 4'b0100;
  localparam logic [3:0] K_OVR = 4'b0010;
  localparam logic [3:0] K_RDE = 4'b0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, entry_inc, two_line, eight_bit;
  logic       cmd_strobe, data_strobe, err_overrun, err_read, busy;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] sb_q[$];
  logic [7:0] exp_mem [32];

  lcd1602_responder_if bus ();

  lcd1602_responder #(.BUSY_CYCLES(10), .CLEAR_BUSY_CYCLES(40)) dut (
    .clk(clk), .reset(rst), .bus(bus), .rd_addr(rd_addr), .rd_data(rd_data),
    .cursor_addr(cursor_addr), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .entry_inc(entry_inc), .two_line(two_line), .eight_bit(eight_bit),
    .cmd_strobe(cmd_strobe), .data_strobe(data_strobe), .err_overrun(err_overrun),
    .err_read(err_read), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe/error pulse must match the next queued expectation.
  always @(negedge clk) begin
    logic [3:0] ev, ex;
    ev = {cmd_strobe, data_strobe, err_overrun, err_read};
    if (!rst && ev != 4'b0000) begin
      ex = (sb_q.size() != 0) ? sb_q.pop_front() : 4'b0000;
      checks++;
      assert (ev === ex) else begin
        errors++;
        $error("FAIL event observed %b expected %b", ev, ex);
      end
    end
  end

  task automatic bus_xfer(input logic r_s, input logic r_w, input logic [7:0] d,
                          input logic [3:0] kind, input int hi);
    if (kind != 4'b0000) sb_q.push_back(kind);
    @(posedge clk); #1;
    bus.rs = r_s; bus.rw = r_w; bus.data = d; bus.enable = 1'b1;
    repeat (hi) @(posedge clk);
    #1 bus.enable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [7:0] d);
    bus_xfer(1'b0, 1'b0, d, K_CMD, 4);
  endtask

  task automatic wr(input logic [7:0] d);
    bus_xfer(1'b1, 1'b0, d, K_DAT, 4);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  task automatic release_and_count();
    int n = 0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("busy_after_reset", n, 32);
  endtask

  task automatic mirror_chk(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk) rd_addr = 5'(i);
      @(posedge clk); #1;
      chk(tag, {i[7:0], rd_data}, {i[7:0], exp_mem[i]});
    end
  endtask

  initial begin
    bus.rs = 1'b0; bus.rw = 1'b0; bus.data = 8'h00; bus.enable = 1'b0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cursor", cursor_addr, 7'h00);
    chk("rst_flags", {display_on, cursor_on, blink_on, two_line, entry_inc, eight_bit}, 6'b000011);
    chk("rst_events", {cmd_strobe, data_strobe, err_overrun, err_read}, 4'b0000);

    release_and_count();
    mirror_chk("mirror_init");

    // Execute latency: strobe on the 3rd edge after enable first sampled low
    sb_q.push_back(K_CMD);
    @(posedge clk); #1;
    bus.rs = 1'b0; bus.rw = 1'b0; bus.data = 8'h38; bus.enable = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("lat_edge2", cmd_strobe, 0);
    @(posedge clk);
    #1 chk("lat_edge3", cmd_strobe, 1);
    repeat (3) @(posedge clk);

    cmd(8'h06); cmd(8'h0C); cmd(8'h01);
    wait_idle();
    chk("init_flags", {two_line, eight_bit, entry_inc, display_on, cursor_on, blink_on}, 6'b111100);
    chk("init_cursor", cursor_addr, 7'h00);

    for (int i = 0; i < 16; i++) begin
      wr(8'h41);
      exp_mem[i] = 8'h41;
    end
    cmd(8'hC0);
    wr(8'h42);
    exp_mem[16] = 8'h42;
    chk("line2_cursor", cursor_addr, 7'h41);
    mirror_chk("mirror_lines");

    // Cursor wrap and off-screen writes
    cmd(8'hA7); wr(8'h55);
    chk("wrap_27_40", cursor_addr, 7'h40);
    cmd(8'h04); cmd(8'h80); wr(8'h33);
    exp_mem[0] = 8'h33;
    chk("wrap_00_67", cursor_addr, 7'h67);
    cmd(8'hA0); wr(8'h77);
    chk("dec_offscreen", cursor_addr, 7'h1F);
    mirror_chk("mirror_offscreen");
    cmd(8'h14);
    chk("shift_right", cursor_addr, 7'h20);
    cmd(8'h06);
    chk("entry_inc_set", entry_inc, 1);

    bus_xfer(1'b1, 1'b1, 8'h99, K_RDE, 4);
    chk("read_no_effect", cursor_addr, 7'h20);

`ifndef LCD_BUSY_MODEL_EN
    // Captures during clear: first held pending, second overruns
    cmd(8'h01);
    bus_xfer(1'b1, 1'b0, 8'h61, 4'b0000, 4);
    bus_xfer(1'b1, 1'b0, 8'h62, K_OVR, 4);
    sb_q.push_back(K_DAT);
    wait_idle();
    repeat (4) @(posedge clk);
    wait_idle();
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
    exp_mem[0] = 8'h61;
    mirror_chk("mirror_pending");
    chk("pending_cursor", cursor_addr, 7'h01);
`else
    // Write shortly after a prior execute is dropped while the busy timer runs
    cmd(8'h80);
    wr(8'h71);
    bus_xfer(1'b1, 1'b0, 8'h72, K_OVR, 1);
    wait_idle();
    exp_mem[0] = 8'h71;
    mirror_chk("mirror_busy_drop");
    chk("busy_cursor", cursor_addr, 7'h01);
    bus_xfer(1'b1, 1'b1, 8'h00, K_RDE, 1);
    chk("busy_read_cursor", cursor_addr, 7'h01);
`endif

    // Reset in the middle of a clear restarts the fill from index 0
    cmd(8'h01);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    chk("midclr_flags", {two_line, display_on, entry_inc}, 3'b001);
    release_and_count();
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
    mirror_chk("mirror_after_reset");
    chk("final_cursor", cursor_addr, 7'h00);

    repeat (5) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
